// File: rtl/dma_utils_pkg.sv
// Shared AXI4 types, response/burst constants and the burst address-advance helper
// used by the DMA memory slave.
package dma_utils_pkg;
   localparam int AXI_ADDR_W     = 32;
   localparam int AXI_DATA_W     = 32;
   localparam int AXI_ID_W       = 4;
   localparam int AXI_DATA_BYTES = AXI_DATA_W / 8;

   typedef logic [AXI_ADDR_W-1:0]     axi_addr_t;
   typedef logic [AXI_DATA_W-1:0]     axi_data_t;
   typedef logic [AXI_DATA_BYTES-1:0] axi_strb_t;
   typedef logic [AXI_ID_W-1:0]       axi_id_t;
   typedef logic [7:0]                axi_len_t;
   typedef logic [2:0]                axi_size_t;
   typedef logic [1:0]                axi_burst_t;
   typedef logic [1:0]                axi_error_t;

   localparam axi_error_t AXI_OKAY        = 2'b00;
   localparam axi_error_t AXI_SLVERR      = 2'b10;
   localparam axi_burst_t AXI_BURST_FIXED = 2'b00;
   localparam axi_burst_t AXI_BURST_INCR  = 2'b01;
   localparam axi_burst_t AXI_BURST_WRAP  = 2'b10;
   localparam axi_size_t  AXI_SIZE_MAX    = axi_size_t'($clog2(AXI_DATA_BYTES));

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} axi_wr_state_e;
   typedef enum logic       {R_IDLE, R_DATA}         axi_rd_state_e;

   typedef struct packed {
      axi_id_t    awid;
      axi_addr_t  awaddr;
      axi_len_t   awlen;
      axi_size_t  awsize;
      axi_burst_t awburst;
      logic       awvalid;
      axi_data_t  wdata;
      axi_strb_t  wstrb;
      logic       wlast;
      logic       wvalid;
      logic       bready;
      axi_id_t    arid;
      axi_addr_t  araddr;
      axi_len_t   arlen;
      axi_size_t  arsize;
      axi_burst_t arburst;
      logic       arvalid;
      logic       rready;
   } s_axi_mosi_t;

   typedef struct packed {
      logic       awready;
      logic       wready;
      axi_id_t    bid;
      axi_error_t bresp;
      logic       buser;
      logic       bvalid;
      logic       arready;
      axi_id_t    rid;
      axi_data_t  rdata;
      axi_error_t rresp;
      logic       rlast;
      logic       ruser;
      logic       rvalid;
   } s_axi_miso_t;

   // WRAP keeps the upper bits of the aligned (len+1)*2^size window and lets the low bits roll.
   function automatic axi_addr_t axi_next_addr(axi_addr_t addr, axi_size_t size,
                                               axi_burst_t burst, axi_len_t len);
      axi_addr_t incr, span, nxt;
      incr = axi_addr_t'(1) << size;
      span = (axi_addr_t'(len) + axi_addr_t'(1)) << size;
      nxt  = addr + incr;
      case (burst)
         AXI_BURST_FIXED: return addr;
         AXI_BURST_WRAP:  return (addr & ~(span - axi_addr_t'(1))) | (nxt & (span - axi_addr_t'(1)));
         default:         return nxt;
      endcase
   endfunction
endpackage

// File: rtl/axi_mem_slave_if.sv
// AXI4 request/response bundle between the DMA master and the memory slave.
interface axi_mem_slave_if
   import dma_utils_pkg::*;
();
   s_axi_mosi_t mosi;
   s_axi_miso_t miso;

   modport master (output mosi, input miso);
   modport slave  (input mosi, output miso);
endinterface

// File: rtl/axi_mem_slave_burst_addr.sv
// Per-channel burst tracker: address advance, beat counter, range and burst-error checks.
// WRAP bursts are legal only when AXI_MEM_WRAP_EN is defined.
module axi_mem_slave_burst_addr
   import dma_utils_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 4096,
   parameter axi_addr_t   BASE_ADDR = '0,
   parameter int unsigned IDX_W     = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld_i,
   input  axi_addr_t        addr_i,
   input  axi_len_t         len_i,
   input  axi_size_t        size_i,
   input  axi_burst_t       burst_i,
   input  logic             adv_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             last_o,
   output logic             err_o
);
   localparam int unsigned OFF_W = $clog2(AXI_DATA_BYTES);

   axi_addr_t  addr_q, addr_d, off;
   axi_len_t   len_q, len_d, cnt_q, cnt_d;
   axi_size_t  size_q, size_d;
   axi_burst_t burst_q, burst_d;
   logic       berr_q, berr_d, wrap_bad;

   always_comb begin
`ifdef AXI_MEM_WRAP_EN
      wrap_bad = !(len_i == 8'd1 || len_i == 8'd3 || len_i == 8'd7 || len_i == 8'd15);
`else
      wrap_bad = 1'b1;
`endif
      addr_d  = addr_q;
      len_d   = len_q;
      size_d  = size_q;
      burst_d = burst_q;
      cnt_d   = cnt_q;
      berr_d  = berr_q;
      if (ld_i) begin
         addr_d  = addr_i;
         len_d   = len_i;
         size_d  = size_i;
         burst_d = burst_i;
         cnt_d   = '0;
         berr_d  = (size_i > AXI_SIZE_MAX) || (burst_i == 2'b11) ||
                   (burst_i == AXI_BURST_WRAP && wrap_bad);
      end else if (adv_i) begin
         addr_d = axi_next_addr(addr_q, size_q, burst_q, len_q);
         cnt_d  = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         len_q   <= '0;
         size_q  <= '0;
         burst_q <= '0;
         cnt_q   <= '0;
         berr_q  <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         len_q   <= len_d;
         size_q  <= size_d;
         burst_q <= burst_d;
         cnt_q   <= cnt_d;
         berr_q  <= berr_d;
      end
   end

   // Offset is modular, so addresses below BASE_ADDR land far above MEM_BYTES.
   assign off    = addr_q - BASE_ADDR;
   assign idx_o  = off[IDX_W+OFF_W-1:OFF_W];
   assign last_o = (cnt_q == len_q);
   assign err_o  = berr_q || !(off < axi_addr_t'(MEM_BYTES));
endmodule

// File: rtl/axi_mem_slave.sv
// Single-port AXI4 memory slave with independent write and read FSMs, one burst each.
// Optional WRAP support is selected by AXI_MEM_WRAP_EN.
module axi_mem_slave
   import dma_utils_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 4096,
   parameter axi_addr_t   BASE_ADDR = '0
) (
   input  logic        clk,
   input  logic        rst,
   input  s_axi_mosi_t axi_mosi_i,
   output s_axi_miso_t axi_miso_o
);
   localparam int unsigned WORDS = MEM_BYTES / AXI_DATA_BYTES;
   localparam int unsigned IDX_W = $clog2(WORDS);

   axi_wr_state_e    w_state_q, w_state_d;
   axi_rd_state_e    r_state_q, r_state_d;
   axi_id_t          awid_q, awid_d, arid_q, arid_d;
   logic             berr_q, berr_d;
   logic             w_ld, w_adv, w_last, w_err, mem_we;
   logic             r_ld, r_adv, r_last, r_err;
   logic [IDX_W-1:0] w_idx, r_idx;
   axi_data_t        mem_q [WORDS];

   axi_mem_slave_burst_addr #(.MEM_BYTES(MEM_BYTES), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)) u_wr_addr (
      .clk, .rst, .ld_i(w_ld), .addr_i(axi_mosi_i.awaddr), .len_i(axi_mosi_i.awlen),
      .size_i(axi_mosi_i.awsize), .burst_i(axi_mosi_i.awburst), .adv_i(w_adv),
      .idx_o(w_idx), .last_o(w_last), .err_o(w_err));

   axi_mem_slave_burst_addr #(.MEM_BYTES(MEM_BYTES), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)) u_rd_addr (
      .clk, .rst, .ld_i(r_ld), .addr_i(axi_mosi_i.araddr), .len_i(axi_mosi_i.arlen),
      .size_i(axi_mosi_i.arsize), .burst_i(axi_mosi_i.arburst), .adv_i(r_adv),
      .idx_o(r_idx), .last_o(r_last), .err_o(r_err));

   always_comb begin
      w_state_d = w_state_q;
      awid_d    = awid_q;
      berr_d    = berr_q;
      w_ld      = 1'b0;
      w_adv     = 1'b0;
      mem_we    = 1'b0;
      case (w_state_q)
         W_IDLE: if (axi_mosi_i.awvalid) begin
            w_ld      = 1'b1;
            awid_d    = axi_mosi_i.awid;
            berr_d    = 1'b0;
            w_state_d = W_DATA;
         end
         W_DATA: if (axi_mosi_i.wvalid) begin
            w_adv  = 1'b1;
            mem_we = !w_err && !rst;
            // wlast on any beat other than awlen marks the burst as failed.
            berr_d = berr_q || w_err || (axi_mosi_i.wlast != w_last);
            if (axi_mosi_i.wlast) w_state_d = W_RESP;
         end
         W_RESP: if (axi_mosi_i.bready) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_d = r_state_q;
      arid_d    = arid_q;
      r_ld      = 1'b0;
      r_adv     = 1'b0;
      case (r_state_q)
         R_IDLE: if (axi_mosi_i.arvalid) begin
            r_ld      = 1'b1;
            arid_d    = axi_mosi_i.arid;
            r_state_d = R_DATA;
         end
         R_DATA: if (axi_mosi_i.rready) begin
            r_adv = 1'b1;
            if (r_last) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         awid_q    <= '0;
         arid_q    <= '0;
         berr_q    <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         awid_q    <= awid_d;
         arid_q    <= arid_d;
         berr_q    <= berr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we)
         for (int b = 0; b < AXI_DATA_BYTES; b++)
            if (axi_mosi_i.wstrb[b]) mem_q[w_idx][8*b +: 8] <= axi_mosi_i.wdata[8*b +: 8];
   end

   // Read data is taken combinationally, so a same-cycle write is only seen after the edge.
   always_comb begin
      axi_miso_o         = '0;
      axi_miso_o.awready = !rst && (w_state_q == W_IDLE);
      axi_miso_o.wready  = !rst && (w_state_q == W_DATA);
      axi_miso_o.bvalid  = !rst && (w_state_q == W_RESP);
      axi_miso_o.bid     = awid_q;
      axi_miso_o.bresp   = berr_q ? AXI_SLVERR : AXI_OKAY;
      axi_miso_o.arready = !rst && (r_state_q == R_IDLE);
      axi_miso_o.rvalid  = !rst && (r_state_q == R_DATA);
      if (axi_miso_o.rvalid) begin
         axi_miso_o.rid   = arid_q;
         axi_miso_o.rlast = r_last;
         axi_miso_o.rresp = r_err ? AXI_SLVERR : AXI_OKAY;
         axi_miso_o.rdata = r_err ? '0 : mem_q[r_idx];
      end
   end
endmodule

// File: tb/tb_axi_mem_slave.sv
// Randomized bench for axi_mem_slave against a byte-array reference memory.
// Expectations for WRAP bursts follow AXI_MEM_WRAP_EN.
module tb_axi_mem_slave;
   import dma_utils_pkg::*;

   localparam int unsigned MEM_BYTES = 4096;
   localparam axi_addr_t   BASE      = '0;
`ifdef AXI_MEM_WRAP_EN
   localparam bit WRAP_EN = 1'b1;
`else
   localparam bit WRAP_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axi_mem_slave_if bus();

   axi_mem_slave #(.MEM_BYTES(MEM_BYTES), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .axi_mosi_i(bus.mosi), .axi_miso_o(bus.miso));

   int          vectors = 0;
   int          miscompares = 0;
   logic [7:0]  mref [MEM_BYTES];
   logic [31:0] wd_buf [64];
   logic [3:0]  ws_buf [64];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Beat address from first principles: FIXED holds, INCR steps, WRAP rolls in the aligned window.
   function automatic axi_addr_t m_addr(axi_addr_t a0, int beat, int size, int burst, int len);
      longint a, nb, total, base;
      a  = longint'(a0);
      nb = longint'(1) << size;
      case (burst)
         0: return a0;
         2: begin
            total = longint'(len + 1) * nb;
            base  = (a / total) * total;
            return axi_addr_t'(base + ((a - base) + longint'(beat) * nb) % total);
         end
         default: return axi_addr_t'(a + longint'(beat) * nb);
      endcase
   endfunction

   function automatic bit m_berr(int size, int burst, int len);
      if (size > 2 || burst == 3) return 1'b1;
      if (burst == 2) return !WRAP_EN || !(len == 1 || len == 3 || len == 7 || len == 15);
      return 1'b0;
   endfunction

   function automatic bit m_in(axi_addr_t a);
      axi_addr_t off;
      off = a - BASE;
      return off < axi_addr_t'(MEM_BYTES);
   endfunction

   function automatic logic [31:0] m_word(axi_addr_t a);
      axi_addr_t off;
      off = (a - BASE) & ~axi_addr_t'(3);
      return {mref[off+3], mref[off+2], mref[off+1], mref[off]};
   endfunction

   task automatic do_write(input int id, input axi_addr_t addr, input int len, input int size,
                           input int burst, input int nbeats, input int bhold, input bit gaps);
      bit        be, berr;
      axi_addr_t a, off;
      be   = m_berr(size, burst, len);
      berr = be || (nbeats != len + 1);
      @(negedge clk);
      bus.mosi.awvalid = 1'b1;
      bus.mosi.awid    = axi_id_t'(id);
      bus.mosi.awaddr  = addr;
      bus.mosi.awlen   = axi_len_t'(len);
      bus.mosi.awsize  = axi_size_t'(size);
      bus.mosi.awburst = axi_burst_t'(burst);
      chk("awready", bus.miso.awready, 1);
      @(negedge clk);
      bus.mosi.awvalid = 1'b0;
      for (int i = 0; i < nbeats; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
         bus.mosi.wvalid = 1'b1;
         bus.mosi.wdata  = wd_buf[i];
         bus.mosi.wstrb  = ws_buf[i];
         bus.mosi.wlast  = (i == nbeats - 1);
         chk("wready", bus.miso.wready, 1);
         a = m_addr(addr, i, size, burst, len);
         if (be || !m_in(a)) berr = 1'b1;
         else begin
            off = (a - BASE) & ~axi_addr_t'(3);
            for (int j = 0; j < 4; j++)
               if (ws_buf[i][j]) mref[off+axi_addr_t'(j)] = wd_buf[i][8*j +: 8];
         end
         @(negedge clk);
         bus.mosi.wvalid = 1'b0;
         bus.mosi.wlast  = 1'b0;
      end
      for (int c = 0; c < bhold; c++) begin
         chk("bvalid_hold", bus.miso.bvalid, 1);
         chk("awready_hold", bus.miso.awready, 0);
         @(negedge clk);
      end
      bus.mosi.bready = 1'b1;
      chk("bvalid", bus.miso.bvalid, 1);
      chk("bresp", bus.miso.bresp, berr ? AXI_SLVERR : AXI_OKAY);
      chk("bid", bus.miso.bid, id);
      chk("user", {bus.miso.buser, bus.miso.ruser}, 0);
      @(negedge clk);
      bus.mosi.bready = 1'b0;
      chk("awready_after_b", bus.miso.awready, 1);
   endtask

   task automatic do_read(input int id, input axi_addr_t addr, input int len, input int size,
                          input int burst, input bit gaps);
      bit        be, err;
      axi_addr_t a;
      be = m_berr(size, burst, len);
      @(negedge clk);
      bus.mosi.arvalid = 1'b1;
      bus.mosi.arid    = axi_id_t'(id);
      bus.mosi.araddr  = addr;
      bus.mosi.arlen   = axi_len_t'(len);
      bus.mosi.arsize  = axi_size_t'(size);
      bus.mosi.arburst = axi_burst_t'(burst);
      chk("arready", bus.miso.arready, 1);
      @(negedge clk);
      bus.mosi.arvalid = 1'b0;
      chk("rvalid_first", bus.miso.rvalid, 1);
      for (int i = 0; i <= len; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
         bus.mosi.rready = 1'b1;
         a   = m_addr(addr, i, size, burst, len);
         err = be || !m_in(a);
         chk("rdata", bus.miso.rdata, err ? 32'h0 : m_word(a));
         chk("rresp", bus.miso.rresp, err ? AXI_SLVERR : AXI_OKAY);
         chk("rlast", bus.miso.rlast, i == len);
         chk("rid", bus.miso.rid, id);
         @(negedge clk);
         bus.mosi.rready = 1'b0;
      end
      chk("arready_after_r", bus.miso.arready, 1);
      chk("rdata_idle", {bus.miso.rvalid, bus.miso.rdata}, 0);
   endtask

   initial begin
      axi_addr_t ra;
      logic [31:0] old_w, new_w;
      int len, size, burst, nb;
      bus.mosi = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {bus.miso.awready, bus.miso.wready, bus.miso.arready}, 0);
      chk("rst_valid", {bus.miso.bvalid, bus.miso.rvalid}, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_aw_ar", {bus.miso.awready, bus.miso.arready}, 2'b11);

      // Fill the whole memory so every later read has a known reference.
      for (int blk = 0; blk < int'(MEM_BYTES) / 64; blk++) begin
         for (int i = 0; i < 16; i++) begin wd_buf[i] = $urandom; ws_buf[i] = 4'hF; end
         do_write(blk % 16, BASE + axi_addr_t'(blk * 64), 15, 2, 1, 16, 0, 1'b0);
      end

      for (int i = 0; i < 4; i++) begin wd_buf[i] = 32'h11 * (i + 1); ws_buf[i] = 4'hF; end
      do_write(7, 32'h100, 3, 2, 1, 4, 0, 1'b0);
      do_read(9, 32'h100, 3, 2, 1, 1'b0);

      wd_buf[0] = 32'h0; ws_buf[0] = 4'hF;
      do_write(1, 32'h0, 0, 2, 1, 1, 0, 1'b0);
      wd_buf[0] = 32'hAABBCCDD; ws_buf[0] = 4'h5;
      do_write(1, 32'h0, 0, 2, 1, 1, 0, 1'b0);
      do_read(2, 32'h0, 0, 2, 1, 1'b0);

      do_read(3, BASE + MEM_BYTES - 4, 1, 2, 1, 1'b0);
      wd_buf[0] = 32'hDEADBEEF; ws_buf[0] = 4'hF;
      do_write(4, 32'h40, 0, 3, 1, 1, 0, 1'b0);
      do_read(4, 32'h40, 0, 2, 1, 1'b0);

      for (int i = 0; i < 4; i++) begin wd_buf[i] = 32'hA0 + i; ws_buf[i] = 4'hF; end
      do_write(5, 32'h0C, 3, 2, 2, 4, 0, 1'b0);
      do_read(5, 32'h00, 3, 2, 1, 1'b0);

      wd_buf[0] = 32'h5A5A5A5A; ws_buf[0] = 4'hF;
      do_write(6, 32'h80, 0, 2, 1, 1, 5, 1'b0);

      // wlast early (2 of 4 beats) and late (3 of 2 beats)
      for (int i = 0; i < 4; i++) begin wd_buf[i] = $urandom; ws_buf[i] = 4'hF; end
      do_write(8, 32'h180, 3, 2, 1, 2, 0, 1'b0);
      do_write(8, 32'h1C0, 1, 2, 1, 3, 0, 1'b0);
      do_read(8, 32'h180, 3, 2, 1, 1'b0);
      do_read(8, 32'h1C0, 3, 2, 1, 1'b0);

      // Same word read and written in the same cycle
      ra = 32'h200;
      old_w = m_word(ra);
      new_w = ~old_w;
      @(negedge clk);
      bus.mosi.awvalid = 1'b1; bus.mosi.awid = 4'd3; bus.mosi.awaddr = ra;
      bus.mosi.awlen = 8'd0; bus.mosi.awsize = 3'd2; bus.mosi.awburst = AXI_BURST_INCR;
      bus.mosi.arvalid = 1'b1; bus.mosi.arid = 4'd5; bus.mosi.araddr = ra;
      bus.mosi.arlen = 8'd0; bus.mosi.arsize = 3'd2; bus.mosi.arburst = AXI_BURST_INCR;
      @(negedge clk);
      bus.mosi.awvalid = 1'b0; bus.mosi.arvalid = 1'b0;
      bus.mosi.wvalid = 1'b1; bus.mosi.wdata = new_w; bus.mosi.wstrb = 4'hF; bus.mosi.wlast = 1'b1;
      bus.mosi.rready = 1'b1;
      chk("conc_wready", bus.miso.wready, 1);
      chk("conc_rdata", bus.miso.rdata, old_w);
      @(negedge clk);
      bus.mosi.wvalid = 1'b0; bus.mosi.wlast = 1'b0; bus.mosi.rready = 1'b0;
      {mref[ra+3], mref[ra+2], mref[ra+1], mref[ra]} = new_w;
      bus.mosi.bready = 1'b1;
      chk("conc_bresp", {bus.miso.bvalid, bus.miso.bresp}, {1'b1, AXI_OKAY});
      @(negedge clk);
      bus.mosi.bready = 1'b0;
      do_read(5, ra, 0, 2, 1, 1'b0);

      for (int t = 0; t < 40; t++) begin
         len   = $urandom_range(0, 15);
         size  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
         burst = $urandom_range(0, 9);
         burst = (burst < 2) ? 0 : (burst < 7) ? 1 : (burst < 9) ? 2 : 3;
         ra    = ($urandom_range(0, 4) == 0) ? BASE + MEM_BYTES - axi_addr_t'($urandom_range(1, 32))
                                              : BASE + axi_addr_t'($urandom_range(0, MEM_BYTES - 1));
         if (burst == 2) ra = ra & ~((axi_addr_t'(1) << size) - 1);
         nb = len + 1;
         if ($urandom_range(0, 7) == 0) nb = (len > 0 && $urandom_range(0, 1) == 0) ? len : len + 2;
         for (int i = 0; i < nb; i++) begin wd_buf[i] = $urandom; ws_buf[i] = 4'($urandom); end
         do_write($urandom_range(0, 15), ra, len, size, burst, nb, $urandom_range(0, 2), 1'b1);
         do_read($urandom_range(0, 15), ra, len, size, burst, 1'b1);
      end

      // Reset after two beats of an 8-beat read
      @(negedge clk);
      bus.mosi.arvalid = 1'b1; bus.mosi.arid = 4'd2; bus.mosi.araddr = 32'h300;
      bus.mosi.arlen = 8'd7; bus.mosi.arsize = 3'd2; bus.mosi.arburst = AXI_BURST_INCR;
      @(negedge clk);
      bus.mosi.arvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.mosi.rready = 1'b1;
         chk("mid_rdata", bus.miso.rdata, m_word(32'h300 + axi_addr_t'(4 * i)));
         @(negedge clk);
      end
      bus.mosi.rready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_rvalid", bus.miso.rvalid, 0);
      chk("rst_arready", bus.miso.arready, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_arready", bus.miso.arready, 1);
      chk("post_rst_rvalid", bus.miso.rvalid, 0);
      do_read(1, 32'h300, 7, 2, 1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 4096, giving the memory size in bytes (power of two, multiple of the bus width in bytes).
REQ-002 SHALL have parameter BASE_ADDR, default 'h0, giving the first byte address decoded by the memory.
REQ-003 SHALL have port clk, input, 1 bit: the only clock.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port axi_mosi_i, input, s_axi_mosi_t: AXI4 requests from the DMA master.
REQ-006 SHALL have port axi_miso_o, output, s_axi_miso_t: AXI4 responses to the DMA master.

Function
REQ-007 SHALL contain a write FSM and a read FSM that run independently, each allowing one outstanding transaction.
REQ-008 Write FSM states SHALL be W_IDLE, W_DATA and W_RESP:
- W_IDLE: awready=1; on awvalid it captures awid, awaddr, awlen, awsize and awburst, then goes to W_DATA.
- W_DATA: wready=1; on wvalid and a valid beat it writes the bytes enabled by wstrb and advances the address; on wlast it goes to W_RESP.
- W_RESP: bvalid=1, bid=captured awid; on bready it goes to W_IDLE.
REQ-009 Read FSM states SHALL be R_IDLE and R_DATA:
- R_IDLE: arready=1; on arvalid it captures arid, araddr, arlen, arsize and arburst, then goes to R_DATA.
- R_DATA: rvalid=1; rdata=full memory word at the current address; rid=arid; rlast=1 when the beat count equals arlen; on rready the beat is consumed; after the last beat it goes to R_IDLE.
REQ-010 Latency SHALL be: first rvalid one cycle after the AR handshake; awready back high one cycle after the B handshake; arready back high one cycle after the last R handshake.
REQ-011 Address advance SHALL be:
- FIXED: address held.
- INCR: address += 2^size.
- Width: the address counter is as wide as axi_addr_t and wraps modulo 2^width.
- No 4 KB boundary check.
REQ-012 Word index SHALL be (addr - BASE_ADDR) >> log2(data bytes); low address bits SHALL NOT shift the data lanes.
REQ-013 A beat whose address lies outside [BASE_ADDR, BASE_ADDR+MEM_BYTES) SHALL get error handling:
- write beat: suppressed.
- read beat: rdata=0, rresp=SLVERR for that beat.
REQ-014 SLVERR SHALL also cover the whole burst, with all of its writes suppressed, when size exceeds the bus width or burst=2'b11.
REQ-015 bresp SHALL be SLVERR if any beat of the burst erred, otherwise OKAY.
REQ-016 bresp SHALL be SLVERR if wlast arrives on a beat count different from awlen. If wlast arrives early, W_RESP is still entered on wlast; if it arrives late, further beats are written with the held/advanced address until wlast.
REQ-017 A read and a write hitting the same word in the same cycle SHALL give the read the old data, because the write takes effect at the clock edge.
REQ-018 Outputs not driven by an FSM SHALL be 0: buser, ruser, and rdata when rvalid=0.

Reset
REQ-019 While rst=1, both FSMs SHALL go to their idle states and awready, wready, arready, bvalid and rvalid SHALL be 0.
REQ-020 The first cycle after rst=0 SHALL have awready=1 and arready=1.
REQ-021 A reset mid-burst SHALL abort the burst with no response; beats already written SHALL remain written.
REQ-022 Memory contents SHALL NOT be reset.

Configuration
REQ-023 With AXI_MEM_WRAP_EN defined, WRAP bursts SHALL be supported:
- wrap boundary = (awlen+1)*2^size;
- address wraps within the aligned window;
- lengths other than 2/4/8/16 give SLVERR for the whole burst.
REQ-024 Without AXI_MEM_WRAP_EN, every WRAP burst SHALL get SLVERR for the whole burst, with writes suppressed; reads return 0 with SLVERR on every beat.

Structure
REQ-025 The following SHALL live in dma_utils_pkg:
- s_axi_mosi_t, s_axi_miso_t, axi_error_t, axi_burst_t and axi_size_t;
- new constants AXI_OKAY, AXI_SLVERR, AXI_BURST_FIXED, AXI_BURST_INCR and AXI_BURST_WRAP;
- new function axi_next_addr(addr, size, burst, len).
REQ-026 A single sub-module, axi_mem_slave_burst_addr, SHALL hold the address advance, wrap and beat-counter logic and SHALL be instantiated once per FSM.

Verification
REQ-027 The bench SHALL cover INCR write: AW addr=0x100, len=3, size=2, data 0x11..0x44, wstrb=0xF -> bresp=OKAY, bid=awid; INCR read of the same -> 0x11,0x22,0x33,0x44 with rlast on beat 4, rid=arid.
REQ-028 The bench SHALL cover strobes: write 0xAABBCCDD with wstrb=0x5 over 0x0 -> read 0x00BB00DD.
REQ-029 The bench SHALL cover out-of-range and bad size:
- read at BASE_ADDR+MEM_BYTES-4, len=1 -> beat 0 OKAY, beat 1 rdata=0 with SLVERR;
- size=3 on a 32-bit bus -> bresp=SLVERR, memory unchanged.
REQ-030 The bench SHALL cover WRAP: write addr=0x0C, len=3, size=2, burst=WRAP -> addresses 0x0C, 0x00, 0x04, 0x08 with AXI_MEM_WRAP_EN defined; SLVERR and memory unchanged without it.
REQ-031 The bench SHALL cover backpressure and concurrency:
- bready held low 5 cycles -> bvalid stays 1, awready stays 0;
- concurrent read and write to the same word -> read returns the pre-write value.
REQ-032 The bench SHALL cover reset mid-read: rst asserted after beat 2 of len=7 -> rvalid=0 next cycle, arready=1 one cycle after rst falls.
